// File: rtl/vram_frame_loader_pkg.sv
// Shared constants, entry layout and FSM encoding for the VRAM frame loader.
// The 128x96 frame is stored row-major: address = row*128 + col.
package vram_frame_loader_pkg;

    localparam int H_PIX        = 128;
    localparam int V_PIX        = 96;
    localparam int FRAME_PIXELS = H_PIX * V_PIX;
    localparam int ADDR_W       = 14;
    localparam int RGB_W        = 3;
    localparam int FIFO_DEPTH   = 16;
    localparam int ENTRY_W      = RGB_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } loader_state_e;

    typedef struct packed {
        logic             sof;
        logic [RGB_W-1:0] data;
    } pix_entry_t;

    function automatic pix_entry_t pack_entry(input logic sof, input logic [RGB_W-1:0] data);
        pix_entry_t e;
        e.sof  = sof;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/vram_frame_loader_if.sv
// Pixel stream (valid/ready) between a pixel source and the frame loader.
interface vram_frame_loader_if;
    import vram_frame_loader_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [RGB_W-1:0] in_data;
    logic             in_sof;

    modport master (
        output in_valid,
        output in_data,
        output in_sof,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sof,
        output in_ready
    );

endinterface

// File: rtl/vram_frame_loader_sync_fifo.sv
// Single-clock FIFO with registered occupancy; DEPTH must be a power of two
// so the read/write pointers wrap on their own.
module sync_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == LVL_W'(DEPTH));
    assign o_empty = (r_count == LVL_W'(0));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_count;

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= LVL_W'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_frame_loader.sv
// Writes a {sof,RGB} pixel stream into the VRAM write port, one pixel per
// clock, optionally only during vertical blanking so the display never tears.
module vram_frame_loader #(
    parameter  int H_PIX      = vram_frame_loader_pkg::H_PIX,
    parameter  int V_PIX      = vram_frame_loader_pkg::V_PIX,
    parameter  int ADDR_W     = vram_frame_loader_pkg::ADDR_W,
    parameter  int FIFO_DEPTH = vram_frame_loader_pkg::FIFO_DEPTH,
    parameter  int BLANK_ONLY = 1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    vram_frame_loader_if.slave                      s_in,
    input  logic                                    vblank,
    output logic                                    wr_en,
    output logic [ADDR_W-1:0]                       wr_addr,
    output logic [vram_frame_loader_pkg::RGB_W-1:0] wr_data,
    output logic                                    frame_done,
    output logic                                    sof_err,
    output logic [LVL_W-1:0]                        fifo_level
);
    import vram_frame_loader_pkg::*;

    localparam logic [ADDR_W-1:0] L_LAST_ADDR = ADDR_W'(H_PIX * V_PIX - 1);
    localparam logic              L_GATED     = (BLANK_ONLY != 32'sd0);

    pix_entry_t       w_wdata;
    logic [ENTRY_W-1:0] w_head_bits;
    pix_entry_t       w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;

    loader_state_e    r_state;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic             r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [RGB_W-1:0] r_wr_data;
    logic             r_frame_done;
    logic             r_sof_err;

    loader_state_e    w_state_nxt;
    logic [ADDR_W-1:0] w_addr_cnt_nxt;
    logic             w_wr_en_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [RGB_W-1:0] w_wr_data_nxt;
    logic             w_frame_done_nxt;
    logic             w_sof_err_nxt;

    assign s_in.in_ready = !w_fifo_full && !reset;
    assign w_push        = s_in.in_valid && s_in.in_ready;
    assign w_wdata       = pack_entry(s_in.in_sof, s_in.in_data);
    assign w_head        = pix_entry_t'(w_head_bits);
    assign w_pop         = !w_fifo_empty && (!L_GATED || vblank);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head_bits),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    // Frame sequencing: addr_cnt is the address the next non-SOF pixel lands on.
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_cnt_nxt   = r_addr_cnt;
        w_wr_en_nxt      = 1'b0;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_frame_done_nxt = 1'b0;
        w_sof_err_nxt    = 1'b0;
        if (w_pop) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_head.sof) begin
                        w_wr_en_nxt    = 1'b1;
                        w_wr_addr_nxt  = ADDR_W'(0);
                        w_wr_data_nxt  = w_head.data;
                        w_addr_cnt_nxt = ADDR_W'(1);
                        w_state_nxt    = ST_WRITE;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_data_nxt = w_head.data;
                    if (w_head.sof && (r_addr_cnt != ADDR_W'(0))) begin
                        w_sof_err_nxt  = 1'b1;
                        w_wr_addr_nxt  = ADDR_W'(0);
                        w_addr_cnt_nxt = ADDR_W'(1);
                    end else if (r_addr_cnt == L_LAST_ADDR) begin
                        w_wr_addr_nxt    = r_addr_cnt;
                        w_frame_done_nxt = 1'b1;
                        w_addr_cnt_nxt   = ADDR_W'(0);
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_wr_addr_nxt  = r_addr_cnt;
                        w_addr_cnt_nxt = r_addr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_addr_cnt_nxt = ADDR_W'(0);
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr_cnt <= ADDR_W'(0);
        end else begin
            r_state    <= w_state_nxt;
            r_addr_cnt <= w_addr_cnt_nxt;
        end
    end

    // Write port is registered so frame_done/sof_err line up with their wr_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= ADDR_W'(0);
            r_wr_data    <= RGB_W'(0);
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_sof_err    <= w_sof_err_nxt;
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_vram_frame_loader.sv
// Bench for vram_frame_loader: a table of FIFO/gating steps, directed frame
// sequences and a random stream, all scored against a frame-position model.
module tb_vram_frame_loader;
    import vram_frame_loader_pkg::*;

    localparam int FRAME = 128 * 96;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        vblank = 1'b0;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [2:0]  wr_data;
    logic        frame_done;
    logic        sof_err;
    logic [4:0]  fifo_level;

    vram_frame_loader_if u_if ();

    vram_frame_loader #(
        .H_PIX(128), .V_PIX(96), .ADDR_W(14), .FIFO_DEPTH(16), .BLANK_ONLY(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_in       (u_if),
        .vblank     (vblank),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: accepted pixels in order, plus the position within the
    // current frame (-1 = no frame open). Discarded pixels resolve lazily.
    logic [3:0] acc_q[$];
    int frame_pos = -1;
    int n_writes = 0, n_done = 0, n_err = 0;
    bit vb_edge = 1'b0;

    initial forever begin
        @(posedge clk);
        vb_edge = vblank;
        if (reset) begin
            acc_q.delete();
            frame_pos = -1;
        end else if (u_if.in_valid && u_if.in_ready) begin
            acc_q.push_back({u_if.in_sof, u_if.in_data});
        end
    end

    initial forever begin
        bit found;
        logic [3:0] e;
        int ea, ed, edone, eerr;
        @(negedge clk);
        if (wr_en) begin
            n_writes++;
            check("blank_gate", vb_edge, 1);
            found = 1'b0;
            while (!found && acc_q.size() > 0) begin
                e = acc_q.pop_front();
                ed = int'(e[2:0]);
                if (e[3]) begin
                    eerr = (frame_pos > 0) ? 1 : 0;
                    ea = 0; edone = 0; frame_pos = 1; found = 1'b1;
                end else if (frame_pos >= 0) begin
                    ea = frame_pos; eerr = 0;
                    edone = (frame_pos == FRAME - 1) ? 1 : 0;
                    frame_pos = edone ? -1 : frame_pos + 1;
                    found = 1'b1;
                end
            end
            if (!found) begin
                check("unexpected_write", 1, 0);
            end else begin
                check("wr_addr", wr_addr, ea);
                check("wr_data", wr_data, ed);
                check("frame_done", frame_done, edone);
                check("sof_err", sof_err, eerr);
            end
        end else begin
            check("done_without_wr", frame_done, 0);
            check("err_without_wr", sof_err, 0);
        end
        if (frame_done) n_done++;
        if (sof_err) n_err++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        u_if.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input bit sof, input int data);
        bit rdy;
        u_if.in_valid = 1'b1;
        u_if.in_sof   = sof;
        u_if.in_data  = 3'(data);
        for (int i = 0; i < 1000; i++) begin
            #1;
            rdy = u_if.in_ready;
            tick();
            if (rdy) return;
        end
        check("send_timeout", 0, 1);
    endtask

    task automatic check_drained(input string tag);
        int guard = 0;
        int pending = 0;
        int pos;
        u_if.in_valid = 1'b0;
        vblank = 1'b1;
        while (fifo_level != 5'd0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_drain_level"}, fifo_level, 0);
        repeat (3) @(negedge clk);
        pos = frame_pos;
        foreach (acc_q[i]) begin
            if (acc_q[i][3] || pos >= 0) begin
                pending++;
                pos = 1;
            end
        end
        check({tag, "_pending_writes"}, pending, 0);
    endtask

    typedef struct {
        bit valid;
        bit vb;
        int lvl;
        bit rdy;
        bit wr;
    } step_t;

    step_t tbl[$];
    int    pix, w0, d0, e0;
    bit    rdy, hit, cur_v, cur_sof;
    logic [2:0] cur_d;

    initial begin
        // Blanking gate: fill to 16 with vblank low, stall 4, then drain.
        for (int k = 0; k < 20; k++)
            tbl.push_back('{1'b1, 1'b0, (k < 16) ? k + 1 : 16, (k + 1 < 16), 1'b0});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{1'b1, 1'b1, 15, 1'b1, 1'b1});
        for (int j = 1; j <= 15; j++)
            tbl.push_back('{1'b0, 1'b1, 15 - j, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 0, 1'b1, 1'b0});

        u_if.in_valid = 1'b1;
        u_if.in_sof   = 1'b1;
        u_if.in_data  = 3'd5;
        reset  = 1'b1;
        vblank = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_in_ready", u_if.in_ready, 0);
            check("rst_wr_en", wr_en, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_sof_err", sof_err, 0);
            check("rst_fifo_level", fifo_level, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        u_if.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", u_if.in_ready, 1);
        check("post_rst_level", fifo_level, 0);

        pix = 0;
        w0 = n_writes;
        foreach (tbl[s]) begin
            u_if.in_valid = tbl[s].valid;
            u_if.in_sof   = (pix == 0);
            u_if.in_data  = 3'(pix);
            vblank        = tbl[s].vb;
            #1;
            rdy = u_if.in_ready;
            @(posedge clk);
            if (tbl[s].valid && rdy) pix++;
            @(negedge clk);
            check("tbl_level", fifo_level, tbl[s].lvl);
            check("tbl_in_ready", u_if.in_ready, tbl[s].rdy);
            check("tbl_wr_en", wr_en, tbl[s].wr);
        end
        u_if.in_valid = 1'b0;
        check("tbl_pixels_accepted", pix, 20);
        check_drained("tbl");
        check("tbl_writes", n_writes - w0, 20);

        // Leading garbage then one full frame, data = addr mod 8.
        do_reset();
        vblank = 1'b1;
        w0 = n_writes; d0 = n_done;
        repeat (5) send(1'b0, int'($urandom_range(0, 7)));
        for (int a = 0; a < FRAME; a++) send(a == 0, a % 8);
        check_drained("frame");
        check("frame_writes", n_writes - w0, FRAME);
        check("frame_done_count", n_done - d0, 1);

        // New SOF at pixel 500 restarts the frame.
        do_reset();
        w0 = n_writes; e0 = n_err;
        for (int p = 0; p < 520; p++) send(p == 0 || p == 500, (p * 3) % 8);
        check_drained("midsof");
        check("midsof_err_count", n_err - e0, 1);
        check("midsof_writes", n_writes - w0, 520);

        // Reset while address 3000 is on the write port.
        do_reset();
        hit = 1'b0;
        for (int p = 0; p < 4000; p++) begin
            send(p == 0, (p + 1) % 8);
            if (wr_en && wr_addr == 14'd3000) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_addr_3000", hit, 1);
        d0 = n_done;
        reset = 1'b1;
        u_if.in_valid = 1'b0;
        tick();
        tick();
        w0 = n_writes;
        reset = 1'b0;
        repeat (6) tick();
        check("abort_no_writes", n_writes - w0, 0);
        check("abort_no_done", n_done - d0, 0);
        for (int a = 0; a < FRAME; a++) send(a == 0, (a + 5) % 8);
        check_drained("restart");
        check("restart_writes", n_writes - w0, FRAME);
        check("restart_done_count", n_done - d0, 1);

        // Random stream, vblank windows, rare SOFs and occasional resets.
        do_reset();
        cur_v = 1'b0;
        cur_sof = 1'b0;
        cur_d = 3'd0;
        for (int c = 0; c < 12000; c++) begin
            if (!cur_v && $urandom_range(0, 9) < 7) begin
                cur_v   = 1'b1;
                cur_sof = ($urandom_range(0, 299) == 0);
                cur_d   = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 39) == 0) vblank = ~vblank;
            reset = ($urandom_range(0, 2999) == 0);
            u_if.in_valid = cur_v;
            u_if.in_sof   = cur_sof;
            u_if.in_data  = cur_d;
            #1;
            rdy = u_if.in_ready;
            tick();
            if (cur_v && rdy) cur_v = 1'b0;
        end
        reset = 1'b0;
        check_drained("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_frame_loader.md
Name: vram_frame_loader

Overview:
- Upstream stage of the VGA display path: accepts a 3-bit RGB pixel stream (valid/ready) and writes it into the video RAM write port.
- Frame size is 128x96, row-major, 12288 pixels; address = row*128 + col, the same mapping the display read path uses.
- A small internal FIFO decouples the source from write gating. With BLANK_ONLY=1, writes occur only during vertical blanking, so the displayed frame never tears.

Parameters:
- H_PIX, 128, image pixels per row
- V_PIX, 96, image rows
- ADDR_W, 14, VRAM address width
- FIFO_DEPTH, 16, input FIFO entries (power of two)
- BLANK_ONLY, 1, 1 = write only while vblank=1; 0 = write whenever data available

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  source pixel valid
- in_ready  out  1  loader can accept; = !fifo_full && !reset
- in_data  in  3  pixel {R,G,B}
- in_sof  in  1  marks first pixel of a frame (qualified by in_valid)
- vblank  in  1  high while vertical display window is inactive (from Vsync stage)
- wr_en  out  1  VRAM write strobe, one pixel per cycle
- wr_addr  out  ADDR_W  VRAM write address
- wr_data  out  3  VRAM write data {R,G,B}
- frame_done  out  1  one-cycle pulse coincident with write of address 12287
- sof_err  out  1  one-cycle pulse: SOF arrived mid-frame
- fifo_level  out  5  current FIFO occupancy, 0..16

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-high, port name reset; all state is sampled on the rising edge of clk.
- Reset: FIFO empty, state IDLE, address counter 0, and wr_en, wr_addr, wr_data, frame_done, sof_err, fifo_level all 0. A reset asserted mid-frame abandons the frame; no partial write completes afterwards.
- FIFO:
  - Entries are {sof, data}, 4 bits wide.
  - Push when in_valid && in_ready; pop when the pop condition below holds.
  - Push and pop in the same cycle leave the level unchanged; the entry order is preserved.
  - Full: in_ready=0, source stalls, and no data is lost. Empty: no pop.
- Pop condition: FIFO not empty && (BLANK_ONLY==0 || vblank==1). vblank dropping stops pops on the next edge; no pixel is dropped.
- FSM states:
  - IDLE:
    - Each popped entry with sof=0 is discarded, no write.
    - A popped entry with sof=1 writes addr 0 and moves to WRITE with addr_cnt=1.
  - WRITE:
    - Each pop writes at addr_cnt, then addr_cnt increments.
    - A pop at addr_cnt = 12287 writes, pulses frame_done and returns to IDLE with addr_cnt=0.
    - A popped entry with sof=1 in WRITE with addr_cnt != 0 pulses sof_err, writes that pixel to addr 0 and sets addr_cnt=1 (the frame restarts).
  - In IDLE, a popped sof=1 entry always passes the addr_cnt == 0 check, so it never raises sof_err.
- Latency:
  - Output registers: wr_en, wr_addr, wr_data, frame_done and sof_err are all registered.
  - An entry popped at edge t appears on the write port during cycle t+1, so frame_done and sof_err align with their wr_en.
  - Minimum in_data-to-wr_en latency is 2 cycles: push at edge t, pop at t+1, wr_en high in cycle t+2.
- Throughput: 1 pixel/clock when data and the write window are available. A full frame needs 12288 write cycles; at 100 MHz a vblank window (~45 lines x 3200 clk) is sufficient.
- Address arithmetic:
  - ADDR_W-bit counter; never exceeds 12287, with explicit wrap to 0 at frame end.
  - Addresses 12288..16383 are never written.

Decomposition:
- Shared package vga_pkg: H_PIX, V_PIX, FRAME_PIXELS = H_PIX*V_PIX (12288), ADDR_W, RGB_W=3, LAST_ADDR=FRAME_PIXELS-1, FSM state encoding (IDLE, WRITE).
- One sub-module: sync_fifo (parameterised width/depth, same clk/reset, level output). The FSM, address counter and output registers live in vram_frame_loader.

Test Plan:
- Reset check: reset high for 3 cycles with in_valid=1 -> in_ready=0 and all outputs 0. First cycle after release -> in_ready=1, fifo_level=0.
- Full frame, BLANK_ONLY=1, vblank=1: 12288 pixels, first with sof, data = addr mod 8 -> 12288 wr_en pulses with wr_addr 0..12287 in order, wr_data = addr mod 8, frame_done exactly once at addr 12287.
- Blanking gate: vblank=0 while 20 pixels are pushed -> fifo_level saturates at 16, in_ready=0, no wr_en. vblank=1 -> 16 writes on consecutive cycles, then the remaining 4 follow.
- Leading garbage: 5 pixels with sof=0 then an sof frame -> no writes for the garbage, first write at addr 0 carries the sof pixel.
- Mid-frame SOF: new sof at pixel 500 -> sof_err one pulse aligned with wr_en at addr 0, subsequent writes at 1, 2, ...
- Reset mid-frame at addr 3000, then a new sof frame -> writes restart at addr 0, no frame_done from the aborted frame.
